ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 95 +++++++++
 rtl/ifetch.sv | 118 +++++++++++
 tb/tb_ifetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the canonical NOP, the fetch-queue
// entry layout and the instruction-fetch FSM encoding.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // addi x0, x0, 0 -- carried as the payload of a misaligned-fetch marker
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One prefetch-queue slot
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] data;
    logic            misalign;
  } fetch_entry_t;

  // RUN: fetching sequentially; FAULT: misaligned target seen, wait for redirect
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } ifetch_state_t;

  // Byte address to instruction-memory word index
  function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] byte_addr);
    return {2'b00, byte_addr[XLEN-1:2]};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue for ifetch. Synchronous FIFO with flush; flush wins over pop,
// but a push in the flush cycle lands as the sole entry (used for fault markers).
// The head is driven from registered storage only, so a push never reaches the
// output in the cycle it is written. An empty queue presents an all-zero head.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_addr;
  logic             push_en;
  logic             pop_en;
  logic             not_empty;
  fetch_entry_t     head_sel;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign not_empty = (count_q != '0);
  // A flush empties the queue, so a simultaneous push always has room
  assign push_en   = push_i & (flush_i | (count_q < CNT_W'(DEPTH)));
  assign pop_en    = pop_i & not_empty & ~flush_i;
  assign wr_addr   = flush_i ? '0 : wr_ptr_q;

  // Next pointer / occupancy computation
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = push_en ? ptr_inc('0) : '0;
      count_d  = push_en ? CNT_W'(1) : '0;
    end else begin
      if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: one write-enabled register per slot; contents need no reset
  // because occupancy gates the head output.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (push_en && (wr_addr == PTR_W'(gi))) begin
        mem_q[gi] <= push_data_i;
      end
    end
  end

  // Head read mux over the registered slots
  always_comb begin
    head_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr_q == PTR_W'(i)) head_sel = mem_q[i];
    end
  end

  assign head_o  = not_empty ? head_sel : '0;
  assign count_o = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch front end: sequential fetch from instruction memory into a
// prefetch queue, execute-stage redirects, and misaligned-target fault markers.
// Build option: IFETCH_PREFETCH_EN -- when defined the queue holds FIFO_DEPTH
// entries; otherwise a single-entry queue is built (one instruction in flight).
module ifetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_drdy,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_misalign
);

`ifdef IFETCH_PREFETCH_EN
  localparam int EFF_DEPTH = FIFO_DEPTH;
`else
  // Single-entry queue; FIFO_DEPTH / FIFO_DEPTH keeps the parameter referenced
  // while always evaluating to one for any legal depth.
  localparam int EFF_DEPTH = FIFO_DEPTH / FIFO_DEPTH;
`endif
  localparam int CNT_W = $clog2(EFF_DEPTH + 1);

  ifetch_state_t    state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_data;
  logic             fetch_done;
  logic             misaligned_redirect;
  logic             fifo_push;
  logic             fifo_pop;
  logic             queue_valid;

  // Request whenever the queue has a free slot; nothing is requested in FAULT
  // or while reset is held.
  assign imem_req = ~rst & (state_q == ST_RUN) & (fifo_count < CNT_W'(EFF_DEPTH));
  assign imem_addr = rst ? word_index(RESET_PC) : word_index(fetch_pc_q);

  // A redirect discards the fetch completing in the same cycle
  assign fetch_done          = imem_req & imem_drdy & ~redirect_valid;
  assign misaligned_redirect = redirect_valid & (redirect_pc[1:0] != 2'b00);

  assign queue_valid = ~rst & (fifo_count != '0);
  assign fifo_pop    = queue_valid & inst_ready & ~redirect_valid;
  assign fifo_push   = fetch_done | misaligned_redirect;

  // Marker for a misaligned target, else the returned instruction word
  always_comb begin
    push_data = '0;
    if (misaligned_redirect) begin
      push_data.pc       = redirect_pc;
      push_data.data     = NOP_INSTR;
      push_data.misalign = 1'b1;
    end else begin
      push_data.pc       = fetch_pc_q;
      push_data.data     = imem_rdata;
      push_data.misalign = 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH(EFF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_data_i(push_data),
    .pop_i      (fifo_pop),
    .flush_i    (redirect_valid),
    .count_o    (fifo_count),
    .head_o     (fifo_head)
  );

  // Next state and fetch PC; a redirect overrides sequential advance
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) begin
        state_d    = ST_RUN;
        fetch_pc_d = redirect_pc;
      end else begin
        state_d = ST_FAULT;
      end
    end else if (fetch_done) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // State and fetch PC registers; reset beats any redirect or in-flight fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign inst_valid    = queue_valid;
  assign inst_data     = queue_valid ? fifo_head.data : 32'h0;
  assign inst_pc       = queue_valid ? fifo_head.pc : 32'h0;
  assign inst_misalign = queue_valid & fifo_head.misalign;

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch. Two instances share stimulus: one
// resets to 0x100, the other to 0xFFFFFFFC for the PC wrap case. Instruction
// memory returns the bitwise inverse of the requested word index.
module tb_ifetch;

`ifdef IFETCH_PREFETCH_EN
  localparam int EFF = 4;
`else
  localparam int EFF = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        drdy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ready;

  logic        req_a, valid_a, mis_a;
  logic [31:0] addr_a, data_a, pc_a, rdata_a;
  logic        req_w, valid_w, mis_w;
  logic [31:0] addr_w, data_w, pc_w, rdata_w;

  int checks   = 0;
  int failures = 0;

  assign rdata_a = ~addr_a;
  assign rdata_w = ~addr_w;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .imem_req(req_a), .imem_addr(addr_a),
    .imem_drdy(drdy), .imem_rdata(rdata_a), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(valid_a), .inst_ready(inst_ready),
    .inst_data(data_a), .inst_pc(pc_a), .inst_misalign(mis_a)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(req_w), .imem_addr(addr_w),
    .imem_drdy(drdy), .imem_rdata(rdata_w), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(valid_w), .inst_ready(inst_ready),
    .inst_data(data_w), .inst_pc(pc_w), .inst_misalign(mis_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] dexp(input logic [31:0] pc);
    return ~{2'b00, pc[31:2]};
  endfunction

  // Watchdog: the bench has no open-ended waits, but never let it hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_valid [3];
    logic [31:0] e_pc    [3];
    logic [31:0] e_addr  [3];
    logic [31:0] e_wpc   [3];
    logic [31:0] p_next;
    int          nfetch;
    int          npop;
    int          k;

`ifdef IFETCH_PREFETCH_EN
    e_valid = '{32'd1, 32'd1, 32'd1};
    e_pc    = '{32'h100, 32'h104, 32'h108};
    e_addr  = '{32'h41, 32'h42, 32'h43};
    e_wpc   = '{32'hFFFF_FFFC, 32'h0, 32'h4};
`else
    e_valid = '{32'd1, 32'd0, 32'd1};
    e_pc    = '{32'h100, 32'h0, 32'h104};
    e_addr  = '{32'h41, 32'h41, 32'h42};
    e_wpc   = '{32'hFFFF_FFFC, 32'h0, 32'h0};
`endif

    // ---------------- reset and streaming ----------------
    rst = 1'b1; drdy = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    smp();
    chk("rst_req",   32'(req_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_data",  data_a, 32'h0);
    chk("rst_pc",    pc_a, 32'h0);
    chk("rst_mis",   32'(mis_a), 32'd0);
    chk("rst_addr",  addr_a, 32'h40);
    chk("rst_addr_w", addr_w, 32'h3FFF_FFFF);
    tick(); rst = 1'b0;
    smp();
    chk("c1_req",   32'(req_a), 32'd1);
    chk("c1_addr",  addr_a, 32'h40);
    chk("c1_valid", 32'(valid_a), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick(); smp();
      chk("str_valid", 32'(valid_a), e_valid[c]);
      chk("str_pc",    pc_a, e_pc[c]);
      chk("str_addr",  addr_a, e_addr[c]);
      chk("str_data",  data_a, (e_valid[c] != 0) ? dexp(e_pc[c]) : 32'h0);
      chk("wrap_pc",   pc_w, e_wpc[c]);
      chk("wrap_data", data_w, (e_valid[c] != 0) ? dexp(e_wpc[c]) : 32'h0);
    end

    // ---------------- backpressure ----------------
    tick(); rst = 1'b1; inst_ready = 1'b0; drdy = 1'b1;
    tick(); rst = 1'b0;
    nfetch = 0;
    for (int c = 0; c < 8; c++) begin
      smp();
      if (req_a && drdy) nfetch++;
      tick();
    end
    chk("bp_fetches", 32'(nfetch), 32'(EFF));
    smp();
    chk("bp_req",   32'(req_a), 32'd0);
    chk("bp_valid", 32'(valid_a), 32'd1);
    chk("bp_pc",    pc_a, 32'h100);
    tick(); drdy = 1'b0; inst_ready = 1'b1;
    npop = 0;
    for (int c = 0; c < 12; c++) begin
      smp();
      if (valid_a) begin
        chk("drain_pc",   pc_a, 32'h100 + 32'(4 * npop));
        chk("drain_data", data_a, dexp(32'h100 + 32'(4 * npop)));
        npop++;
      end
      tick();
    end
    chk("drain_count", 32'(npop), 32'(EFF));
    p_next = 32'h100 + 32'(4 * EFF);

    // ---------------- memory stall ----------------
    for (int c = 0; c < 3; c++) begin
      tick(); smp();
      chk("stall_addr",  addr_a, p_next >> 2);
      chk("stall_req",   32'(req_a), 32'd1);
      chk("stall_valid", 32'(valid_a), 32'd0);
    end
    tick(); drdy = 1'b1;
    smp();
    chk("stall_done_addr", addr_a, p_next >> 2);
    tick(); drdy = 1'b0;
    smp();
    chk("stall_push_valid", 32'(valid_a), 32'd1);
    chk("stall_push_pc",    pc_a, p_next);
    chk("stall_push_data",  data_a, dexp(p_next));
    chk("stall_next_addr",  addr_a, (p_next + 32'd4) >> 2);
    tick(); smp();
    chk("stall_popped", 32'(valid_a), 32'd0);

    // ---------------- reset beats redirect ----------------
    tick(); rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h2002;
    drdy = 1'b1; inst_ready = 1'b0;
    tick(); rst = 1'b0; redirect_valid = 1'b0;
    smp();
    chk("rp_valid", 32'(valid_a), 32'd0);
    chk("rp_req",   32'(req_a), 32'd1);
    chk("rp_addr",  addr_a, 32'h40);

    // ---------------- aligned redirect ----------------
    k = (EFF >= 3) ? 3 : EFF;
    for (int c = 0; c < k; c++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h2000; inst_ready = 1'b1;
    smp();
    chk("ar_pre_valid", 32'(valid_a), 32'd1);
    chk("ar_pre_pc",    pc_a, 32'h100);
    tick(); redirect_valid = 1'b0; inst_ready = 1'b0;
    smp();
    chk("ar_flush_valid", 32'(valid_a), 32'd0);
    chk("ar_addr",        addr_a, 32'h800);
    chk("ar_req",         32'(req_a), 32'd1);
    tick(); smp();
    chk("ar_first_pc",   pc_a, 32'h2000);
    chk("ar_first_data", data_a, dexp(32'h2000));
    chk("ar_first_mis",  32'(mis_a), 32'd0);

    // ---------------- misaligned redirect ----------------
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h2002;
    tick(); redirect_valid = 1'b0;
    smp();
    chk("mr_valid", 32'(valid_a), 32'd1);
    chk("mr_pc",    pc_a, 32'h2002);
    chk("mr_data",  data_a, 32'h13);
    chk("mr_mis",   32'(mis_a), 32'd1);
    chk("mr_req",   32'(req_a), 32'd0);
    tick(); smp();
    chk("mr_hold_pc",  pc_a, 32'h2002);
    chk("mr_hold_mis", 32'(mis_a), 32'd1);
    tick(); inst_ready = 1'b1;
    smp();
    tick(); smp();
    chk("mr_after_valid", 32'(valid_a), 32'd0);
    chk("mr_after_req",   32'(req_a), 32'd0);
    tick(); smp();
    chk("mr_idle_valid", 32'(valid_a), 32'd0);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h3000;
    tick(); redirect_valid = 1'b0;
    smp();
    chk("rec_req",   32'(req_a), 32'd1);
    chk("rec_addr",  addr_a, 32'hC00);
    chk("rec_valid", 32'(valid_a), 32'd0);
    tick(); smp();
    chk("rec_pc",  pc_a, 32'h3000);
    chk("rec_mis", 32'(mis_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
